// File: rtl/renesas_cfg_seq.sv
// Walks a record table in the Renesas config BRAM (port B) and turns each
// record into an I2C register-write command or a timed delay.
module renesas_cfg_seq #(
    parameter int         RD_LAT      = 2,
    parameter logic [6:0] DEV_ADDR    = 7'h5B,
    parameter int         DELAY_TICKS = 100000,
    parameter logic [15:0] BASE_ADDR  = 16'h0
) (
    input  logic        i2c_clk,
    input  logic        i2c_rstn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] err_idx,
    output logic        bram_web,
    output logic [15:0] bram_addr,
    output logic [15:0] bram_din,
    input  logic [15:0] bram_dout,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_dev,
    output logic [15:0] cmd_reg,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_HDR   = 4'd1,
        S_RD_A     = 4'd2,
        S_RD_B     = 4'd3,
        S_ISSUE    = 4'd4,
        S_WAIT_RSP = 4'd5,
        S_DELAY    = 4'd6,
        S_DONE     = 4'd7,
        S_ERR      = 4'd8
    } state_t;

    localparam logic [1:0]  LAT   = 2'(RD_LAT);
    localparam logic [31:0] TICKS = 32'(DELAY_TICKS);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  lat_cnt;
    logic        lat_hit;
    logic [15:0] n_rec;
    logic [15:0] idx;
    logic [15:0] idx_x2;
    logic [31:0] dly_cnt;
    logic        dly_end;
    logic        rec_adv;
    logic        rec_last;
    logic        start_acc;

    // The address is held for the whole read state, so bram_dout is valid
    // once the state has been resident for RD_LAT cycles.
    assign lat_hit   = (lat_cnt == LAT);
    assign idx_x2    = {idx[14:0], 1'b0};
    assign dly_end   = (dly_cnt <= 32'd1);
    assign rec_last  = ((idx + 16'd1) == n_rec);
    assign start_acc = (state == S_IDLE) && start;
    assign rec_adv   = ((state == S_WAIT_RSP) && rsp_valid && !rsp_nack) ||
                       ((state == S_DELAY) && dly_end);

    assign bram_web  = 1'b0;
    assign bram_din  = 16'h0000;
    assign cmd_dev   = DEV_ADDR;
    assign state_dbg = state;

    always_ff @(posedge i2c_clk or negedge i2c_rstn) begin
        if (!i2c_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RD_HDR;
            end
            S_RD_HDR: begin
                if (lat_hit) state_nx = (bram_dout == 16'h0000) ? S_DONE : S_RD_A;
            end
            S_RD_A: begin
                if (lat_hit) state_nx = S_RD_B;
            end
            S_RD_B: begin
                if (lat_hit) state_nx = bram_dout[15] ? S_DELAY : S_ISSUE;
            end
            S_ISSUE: begin
                if (cmd_ready) state_nx = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (rsp_valid) begin
                    if (rsp_nack)      state_nx = S_ERR;
                    else if (rec_last) state_nx = S_DONE;
                    else               state_nx = S_RD_A;
                end
            end
            S_DELAY: begin
                if (dly_end) state_nx = rec_last ? S_DONE : S_RD_A;
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i2c_clk or negedge i2c_rstn) begin
        if (!i2c_rstn) begin
            lat_cnt  <= 2'd0;
            n_rec    <= 16'h0000;
            idx      <= 16'h0000;
            dly_cnt  <= 32'd0;
            cmd_reg  <= 16'h0000;
            cmd_data <= 8'h00;
            error    <= 1'b0;
            err_idx  <= 16'h0000;
        end else begin
            if (state_nx != state) begin
                lat_cnt <= 2'd0;
            end else if (!lat_hit) begin
                lat_cnt <= lat_cnt + 2'd1;
            end

            if (start_acc) begin
                idx   <= 16'h0000;
                error <= 1'b0;
            end

            if ((state == S_RD_HDR) && lat_hit) begin
                n_rec <= bram_dout;
            end

            if ((state == S_RD_A) && lat_hit) begin
                cmd_reg <= bram_dout;
            end

            // A zero-length delay loads 0 and still spends one cycle in DELAY.
            if ((state == S_RD_B) && lat_hit) begin
                cmd_data <= bram_dout[7:0];
                dly_cnt  <= {24'h000000, bram_dout[7:0]} * TICKS;
            end else if ((state == S_DELAY) && !dly_end) begin
                dly_cnt <= dly_cnt - 32'd1;
            end

            if (rec_adv && !rec_last) begin
                idx <= idx + 16'd1;
            end

            if ((state == S_WAIT_RSP) && rsp_valid && rsp_nack) begin
                error   <= 1'b1;
                err_idx <= idx;
            end
        end
    end

    // cmd_valid/ready: cmd_valid rises on entering ISSUE without waiting for
    // cmd_ready, cmd_reg/cmd_data are held constant while it is high, and the
    // command transfers on the first rising edge where both are high.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        cmd_valid = 1'b0;
        bram_addr = 16'h0000;
        case (state)
            S_RD_HDR: begin
                busy      = 1'b1;
                bram_addr = BASE_ADDR;
            end
            S_RD_A: begin
                busy      = 1'b1;
                bram_addr = BASE_ADDR + 16'd1 + idx_x2;
            end
            S_RD_B: begin
                busy      = 1'b1;
                bram_addr = BASE_ADDR + 16'd2 + idx_x2;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
            end
            S_WAIT_RSP: busy = 1'b1;
            S_DELAY:    busy = 1'b1;
            S_DONE:     done = 1'b1;
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
